// File: rtl/rf_wb_ctrl_if.sv
// Writeback bus between the three writeback sources and the RF write-port controller.
// RF_WB_STAT_EN adds the conflict_cnt statistics signal.
interface rf_wb_ctrl_if;
  logic        alu_req;
  logic [4:0]  alu_addr;
  logic [31:0] alu_data;
  logic        alu_gnt;
  logic        mem_req;
  logic [4:0]  mem_addr;
  logic [31:0] mem_data;
  logic        mem_gnt;
  logic        md_req;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        md_gnt;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;
  logic        rf_wr;
  logic        init_done;
`ifdef RF_WB_STAT_EN
  logic [15:0] conflict_cnt;
`endif

  modport master (
    output alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data,
           md_req, md_addr, md_data,
    input  alu_gnt, mem_gnt, md_gnt, rf_a3, rf_wd, rf_wr, init_done
`ifdef RF_WB_STAT_EN
    , input conflict_cnt
`endif
  );

  modport slave (
    input  alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data,
           md_req, md_addr, md_data,
    output alu_gnt, mem_gnt, md_gnt, rf_a3, rf_wd, rf_wr, init_done
`ifdef RF_WB_STAT_EN
    , output conflict_cnt
`endif
  );
endinterface

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port controller: writes $gp/$sp after reset, then arbitrates ALU/load/mul-div.
// Optional RF_WB_STAT_EN adds a saturating multi-request conflict counter.
module rf_wb_ctrl #(
  parameter logic [31:0] GP_INIT    = 32'h00001800,
  parameter logic [31:0] SP_INIT    = 32'h00002ffe,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic        clk_i,
  input logic        rst_ni,
  rf_wb_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    ST_INIT_GP = 2'd0,
    ST_INIT_SP = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [3:0] STARVE_SAT = 4'd15;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;
  logic [4:0]  rf_a3_q, rf_a3_d;
  logic [31:0] rf_wd_q, rf_wd_d;
  logic        rf_wr_q, rf_wr_d;
  logic        init_done_q, init_done_d;
  logic        alu_gnt_s, mem_gnt_s, md_gnt_s, md_prio_s, xfer_s;
  logic [4:0]  win_addr_s;
  logic [31:0] win_data_s;

  // Grant arbitration: mem > alu > md unless md has been starved long enough.
  always_comb begin
    alu_gnt_s  = 1'b0;
    mem_gnt_s  = 1'b0;
    md_gnt_s   = 1'b0;
    md_prio_s  = bus.md_req && (starve_q >= STARVE_LIM);
    if (state_q == ST_RUN) begin
      if (md_prio_s) begin
        md_gnt_s = 1'b1;
      end else if (bus.mem_req) begin
        mem_gnt_s = 1'b1;
      end else if (bus.alu_req) begin
        alu_gnt_s = 1'b1;
      end else if (bus.md_req) begin
        md_gnt_s = 1'b1;
      end else begin
        md_gnt_s = 1'b0;
      end
    end else begin
      md_gnt_s = 1'b0;
    end
    xfer_s = alu_gnt_s | mem_gnt_s | md_gnt_s;
    if (mem_gnt_s) begin
      win_addr_s = bus.mem_addr;
      win_data_s = bus.mem_data;
    end else if (alu_gnt_s) begin
      win_addr_s = bus.alu_addr;
      win_data_s = bus.alu_data;
    end else begin
      win_addr_s = bus.md_addr;
      win_data_s = bus.md_data;
    end
  end

  // Next-state logic for the init sequence, RF write registers and starvation counter.
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    rf_a3_d     = rf_a3_q;
    rf_wd_d     = rf_wd_q;
    rf_wr_d     = 1'b0;
    init_done_d = init_done_q;
    case (state_q)
      ST_INIT_GP: begin
        rf_wr_d = 1'b1;
        rf_a3_d = 5'd28;
        rf_wd_d = GP_INIT;
        state_d = ST_INIT_SP;
      end
      ST_INIT_SP: begin
        rf_wr_d     = 1'b1;
        rf_a3_d     = 5'd29;
        rf_wd_d     = SP_INIT;
        init_done_d = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        // r0 writes still complete the handshake and update a3/wd, only the enable is masked.
        if (xfer_s) begin
          rf_a3_d = win_addr_s;
          rf_wd_d = win_data_s;
          rf_wr_d = (win_addr_s != 5'd0);
        end else begin
          rf_wr_d = 1'b0;
        end
        if (!bus.md_req || md_gnt_s) begin
          starve_d = 4'd0;
        end else if (starve_q != STARVE_SAT) begin
          starve_d = starve_q + 4'd1;
        end else begin
          starve_d = starve_q;
        end
      end
      default: begin
        state_d = ST_INIT_GP;
      end
    endcase
  end

  // State and registered RF outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_INIT_GP;
      starve_q    <= 4'd0;
      rf_a3_q     <= 5'd0;
      rf_wd_q     <= 32'd0;
      rf_wr_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      rf_a3_q     <= rf_a3_d;
      rf_wd_q     <= rf_wd_d;
      rf_wr_q     <= rf_wr_d;
      init_done_q <= init_done_d;
    end
  end

  assign bus.alu_gnt   = alu_gnt_s;
  assign bus.mem_gnt   = mem_gnt_s;
  assign bus.md_gnt    = md_gnt_s;
  assign bus.rf_a3     = rf_a3_q;
  assign bus.rf_wd     = rf_wd_q;
  assign bus.rf_wr     = rf_wr_q;
  assign bus.init_done = init_done_q;

`ifdef RF_WB_STAT_EN
  logic [15:0] conflict_q, conflict_d;
  logic [1:0]  nreq_s;

  // Count RUN cycles with two or more simultaneous requests, saturating.
  always_comb begin
    nreq_s = {1'b0, bus.alu_req} + {1'b0, bus.mem_req} + {1'b0, bus.md_req};
    if ((state_q == ST_RUN) && (nreq_s >= 2'd2) && (conflict_q != 16'hffff)) begin
      conflict_d = conflict_q + 16'd1;
    end else begin
      conflict_d = conflict_q;
    end
  end

  // Conflict counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      conflict_q <= 16'd0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign bus.conflict_cnt = conflict_q;
`endif
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: directed table, multi-cycle corner sequences and
// randomized requesters checked against a rule-level reference model.
module tb_rf_wb_ctrl;
  localparam int unsigned STARVE_MAX = 4;
  localparam logic [31:0] GP_INIT = 32'h00001800;
  localparam logic [31:0] SP_INIT = 32'h00002ffe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rf_wb_ctrl_if bus();

  rf_wb_ctrl #(.GP_INIT(GP_INIT), .SP_INIT(SP_INIT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [2:0]  req;       // {md, mem, alu}
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [4:0]  d_addr;
    logic [31:0] d_data;
    logic [2:0]  exp_gnt;   // {md, mem, alu}
    logic        exp_wr;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd;
  } vec_t;

  int vec_cnt = 0;
  int err_cnt = 0;

  // reference model state
  int          starve_m;
  int          conf_m;
  logic [4:0]  last_a3;
  logic [31:0] last_wd;
  logic [2:0]  last_w;

  // sampled DUT values
  logic [2:0]  g_s;
  logic        wr_s;
  logic [4:0]  a3_s;
  logic [31:0] wd_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] req, input logic [4:0] aa, input logic [31:0] ad,
                       input logic [4:0] ma, input logic [31:0] mdt,
                       input logic [4:0] da, input logic [31:0] dd);
    bus.alu_req = req[0]; bus.alu_addr = aa; bus.alu_data = ad;
    bus.mem_req = req[1]; bus.mem_addr = ma; bus.mem_data = mdt;
    bus.md_req  = req[2]; bus.md_addr  = da; bus.md_data  = dd;
  endtask

  // One RUN cycle: drive at negedge, check grant mid-cycle, check RF outputs after the edge.
  task automatic run_step(input logic [2:0] req, input logic [4:0] aa, input logic [31:0] ad,
                          input logic [4:0] ma, input logic [31:0] mdt,
                          input logic [4:0] da, input logic [31:0] dd);
    logic [2:0] w;
    logic       exp_wr;
    int         nreq;
    if (req[2] && starve_m >= int'(STARVE_MAX)) w = 3'b100;
    else if (req[1]) w = 3'b010;
    else if (req[0]) w = 3'b001;
    else if (req[2]) w = 3'b100;
    else w = 3'b000;
    @(negedge clk);
    drive(req, aa, ad, ma, mdt, da, dd);
    #1;
    g_s = {bus.md_gnt, bus.mem_gnt, bus.alu_gnt};
    chk("gnt", 32'(g_s), 32'(w));
    @(posedge clk);
    #1;
    wr_s = bus.rf_wr; a3_s = bus.rf_a3; wd_s = bus.rf_wd;
    if (w == 3'b010) begin last_a3 = ma; last_wd = mdt; end
    else if (w == 3'b001) begin last_a3 = aa; last_wd = ad; end
    else if (w == 3'b100) begin last_a3 = da; last_wd = dd; end
    exp_wr = (w != 3'b000) && (last_a3 != 5'd0);
    chk("rf_wr", 32'(wr_s), 32'(exp_wr));
    chk("rf_a3", 32'(a3_s), 32'(last_a3));
    chk("rf_wd", wd_s, last_wd);
    if (!req[2] || w == 3'b100) starve_m = 0;
    else if (starve_m < 15) starve_m++;
    nreq = int'(req[0]) + int'(req[1]) + int'(req[2]);
    if (nreq >= 2 && conf_m < 65535) conf_m++;
`ifdef RF_WB_STAT_EN
    chk("conflict_cnt", 32'(bus.conflict_cnt), 32'(conf_m));
`endif
    last_w = w;
  endtask

  // Init sequence after reset release (called right after the releasing negedge).
  task automatic init_seq();
    #1;
    chk("init_gp_gnt", 32'({bus.md_gnt, bus.mem_gnt, bus.alu_gnt}), 32'd0);
    @(posedge clk); #1;
    chk("init_gp_wr", 32'(bus.rf_wr), 32'd1);
    chk("init_gp_a3", 32'(bus.rf_a3), 32'd28);
    chk("init_gp_wd", bus.rf_wd, GP_INIT);
    chk("init_gp_done", 32'(bus.init_done), 32'd0);
    chk("init_sp_gnt", 32'({bus.md_gnt, bus.mem_gnt, bus.alu_gnt}), 32'd0);
    @(posedge clk); #1;
    chk("init_sp_wr", 32'(bus.rf_wr), 32'd1);
    chk("init_sp_a3", 32'(bus.rf_a3), 32'd29);
    chk("init_sp_wd", bus.rf_wd, SP_INIT);
    chk("init_done", 32'(bus.init_done), 32'd1);
    starve_m = 0; conf_m = 0; last_a3 = 5'd29; last_wd = SP_INIT;
  endtask

  function automatic vec_t mk(input logic [2:0] req,
                              input logic [4:0] aa, input logic [31:0] ad,
                              input logic [4:0] ma, input logic [31:0] mdt,
                              input logic [4:0] da, input logic [31:0] dd,
                              input logic [2:0] eg, input logic ew,
                              input logic [4:0] ea, input logic [31:0] ed);
    vec_t v;
    v.req = req; v.a_addr = aa; v.a_data = ad; v.m_addr = ma; v.m_data = mdt;
    v.d_addr = da; v.d_data = dd; v.exp_gnt = eg; v.exp_wr = ew; v.exp_a3 = ea; v.exp_wd = ed;
    return v;
  endfunction

  vec_t tbl[11];

  logic        p_v[3];
  logic [4:0]  p_a[3];
  logic [31:0] p_d[3];
  int          p_prob[3];

  initial begin
    tbl[0]  = mk(3'b011, 5'd5, 32'h11111111, 5'd6, 32'h22222222, 5'd0, 32'h0, 3'b010, 1'b1, 5'd6, 32'h22222222);
    tbl[1]  = mk(3'b001, 5'd5, 32'h11111111, 5'd0, 32'h0, 5'd0, 32'h0, 3'b001, 1'b1, 5'd5, 32'h11111111);
    tbl[2]  = mk(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 3'b000, 1'b0, 5'd5, 32'h11111111);
    tbl[3]  = mk(3'b001, 5'd0, 32'hffffffff, 5'd0, 32'h0, 5'd0, 32'h0, 3'b001, 1'b0, 5'd0, 32'hffffffff);
    tbl[4]  = mk(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 32'hdeadbeef, 3'b100, 1'b1, 5'd9, 32'hdeadbeef);
    tbl[5]  = mk(3'b101, 5'd3, 32'h33333333, 5'd0, 32'h0, 5'd7, 32'h77777777, 3'b001, 1'b1, 5'd3, 32'h33333333);
    tbl[6]  = mk(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 32'h77777777, 3'b100, 1'b1, 5'd7, 32'h77777777);
    tbl[7]  = mk(3'b010, 5'd0, 32'h0, 5'd0, 32'h12345678, 5'd0, 32'h0, 3'b010, 1'b0, 5'd0, 32'h12345678);
    tbl[8]  = mk(3'b111, 5'd2, 32'hbbbb0002, 5'd1, 32'haaaa0001, 5'd4, 32'hcccc0004, 3'b010, 1'b1, 5'd1, 32'haaaa0001);
    tbl[9]  = mk(3'b101, 5'd2, 32'hbbbb0002, 5'd0, 32'h0, 5'd4, 32'hcccc0004, 3'b001, 1'b1, 5'd2, 32'hbbbb0002);
    tbl[10] = mk(3'b100, 5'd0, 32'h0, 5'd0, 32'h0, 5'd4, 32'hcccc0004, 3'b100, 1'b1, 5'd4, 32'hcccc0004);

    // reset state
    rst_n = 1'b0;
    drive(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr", 32'(bus.rf_wr), 32'd0);
    chk("rst_a3", 32'(bus.rf_a3), 32'd0);
    chk("rst_wd", bus.rf_wd, 32'd0);
    chk("rst_done", 32'(bus.init_done), 32'd0);
`ifdef RF_WB_STAT_EN
    chk("rst_conflict", 32'(bus.conflict_cnt), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    init_seq();
    // third edge: idle, rf_wr drops
    run_step(3'b000, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0);

    // directed table
    for (int i = 0; i < 11; i++) begin
      run_step(tbl[i].req, tbl[i].a_addr, tbl[i].a_data, tbl[i].m_addr, tbl[i].m_data,
               tbl[i].d_addr, tbl[i].d_data);
      chk($sformatf("tbl%0d_gnt", i), 32'(g_s), 32'(tbl[i].exp_gnt));
      chk($sformatf("tbl%0d_wr", i), 32'(wr_s), 32'(tbl[i].exp_wr));
      chk($sformatf("tbl%0d_a3", i), 32'(a3_s), 32'(tbl[i].exp_a3));
      chk($sformatf("tbl%0d_wd", i), wd_s, tbl[i].exp_wd);
    end

    // starvation: mem held, md held; md wins after exactly STARVE_MAX denied cycles, twice
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k <= int'(STARVE_MAX); k++) begin
        run_step(3'b110, 5'd0, 32'h0, 5'd6, 32'h66666666, 5'd9, 32'hdeadbeef);
        chk("starve_gnt", 32'(g_s), (k == int'(STARVE_MAX)) ? 32'd4 : 32'd2);
      end
      chk("starve_a3", 32'(a3_s), 32'd9);
      chk("starve_wd", wd_s, 32'hdeadbeef);
    end

    // reset between a grant and the following edge
    @(negedge clk);
    drive(3'b001, 5'd5, 32'h55555555, 5'd0, 32'h0, 5'd0, 32'h0);
    #1;
    chk("pre_rst_gnt", 32'(bus.alu_gnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(bus.rf_wr), 32'd0);
    chk("mid_rst_done", 32'(bus.init_done), 32'd0);
    chk("mid_rst_gnt", 32'(bus.alu_gnt), 32'd0);
    @(posedge clk); #1;
    chk("mid_rst_hold_wr", 32'(bus.rf_wr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    init_seq();
    run_step(3'b001, 5'd5, 32'h55555555, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("post_rst_alu", 32'(g_s), 32'd1);

    // conflict accounting: 3 double-request cycles, 1 single
    for (int k = 0; k < 3; k++) begin
      run_step(3'b011, 5'd5, 32'h55555555, 5'd6, 32'h66666666, 5'd0, 32'h0);
    end
    run_step(3'b010, 5'd0, 32'h0, 5'd6, 32'h66666666, 5'd0, 32'h0);
`ifdef RF_WB_STAT_EN
    chk("conflict_3", 32'(bus.conflict_cnt), 32'd3);
`endif

    // randomized requesters obeying the hold-until-grant rule
    p_prob[0] = 50; p_prob[1] = 60; p_prob[2] = 40;
    for (int s = 0; s < 3; s++) begin
      p_v[s] = 1'b0; p_a[s] = 5'd0; p_d[s] = 32'h0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < 3; s++) begin
        if (!p_v[s] && $urandom_range(0, 99) < p_prob[s]) begin
          p_v[s] = 1'b1;
          p_a[s] = 5'($urandom_range(0, 31));
          p_d[s] = $urandom;
        end
      end
      run_step({p_v[2], p_v[1], p_v[0]}, p_a[0], p_d[0], p_a[1], p_d[1], p_a[2], p_d[2]);
      for (int s = 0; s < 3; s++) begin
        if (last_w[s]) p_v[s] = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
Writeback controller for the 32x32 register file's single write port (A3/WD/RFWr). It arbitrates three writeback sources onto that port: the ALU result, load data from memory, and the multi-cycle mul/div unit. After reset it runs an init sequence that writes $gp (r28) and $sp (r29) through the same port before granting any requester. All RF-facing outputs are registered.

Parameters:
GP_INIT, 32'h00001800, value written to r28 during init
SP_INIT, 32'h00002ffe, value written to r29 during init
STARVE_MAX, 4, consecutive denied md_req cycles before mul/div gets top priority (1..15)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous reset, active-low
alu_req  in  1  ALU writeback request
alu_addr  in  5  ALU destination register
alu_data  in  32  ALU result
alu_gnt  out  1  ALU request accepted this cycle
mem_req  in  1  load writeback request
mem_addr  in  5  load destination register
mem_data  in  32  load data
mem_gnt  out  1  load request accepted this cycle
md_req  in  1  mul/div writeback request
md_addr  in  5  mul/div destination register
md_data  in  32  mul/div result
md_gnt  out  1  mul/div request accepted this cycle
rf_a3  out  5  RF write address (registered)
rf_wd  out  32  RF write data (registered)
rf_wr  out  1  RF write enable (registered)
init_done  out  1  high once init sequence complete

Behaviour:
- Reset (rst low, async): state=INIT_GP, rf_wr=0, rf_a3=0, rf_wd=0, init_done=0, starve counter=0, all gnt=0. A write captured but not yet presented on the RF outputs is discarded.
- FSM: INIT_GP -> INIT_SP -> RUN, one cycle per state. RUN is terminal until reset.
- INIT_GP cycle: at the next edge, rf_wr=1, rf_a3=28, rf_wd=GP_INIT.
- INIT_SP cycle: at the next edge, rf_wr=1, rf_a3=29, rf_wd=SP_INIT, init_done=1.
- All gnt=0 in both INIT states regardless of the requests.
- RUN: the gnt outputs are combinational from the current req inputs and the starve counter. At most one gnt is high per cycle.
- Transfer = req & gnt in the same cycle. The winner's addr/data appear on rf_a3/rf_wd with rf_wr=1 at the next edge (latency 1). With no transfer, rf_wr=0 at the next edge; rf_a3/rf_wd hold their previous values.
- Requester rule: hold req, addr and data stable until gnt is seen. The requester may drop req the cycle after gnt.
- Priority in RUN: mem > alu > md, with one exception: if starve counter >= STARVE_MAX and md_req=1, md wins outright.
- Starve counter:
  - +1 each RUN cycle with md_req=1 and md_gnt=0, saturating at 15.
  - Cleared on md grant.
  - Cleared when md_req=0.
- Writes to r0: the handshake completes normally (gnt asserted), but rf_wr stays 0 at the next edge. rf_a3/rf_wd are still updated.
- Losing requesters see gnt=0 and retry next cycle. No request is lost or duplicated.
- Back-to-back grants to the same source in consecutive cycles are allowed.

Optional Feature:
RF_WB_STAT_EN
- Defined: adds output conflict_cnt[15:0]. Reset to 0. Increments by 1 each RUN cycle in which two or more req inputs are high. Saturates at 16'hffff.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset release with all req=0 -> edge 1: rf_wr=1, a3=28, wd=0x00001800. Edge 2: rf_wr=1, a3=29, wd=0x00002ffe, init_done=1. Edge 3: rf_wr=0.
- In RUN, alu_req (addr 5, 0x11111111) and mem_req (addr 6, 0x22222222) high together -> mem_gnt first, then rf a3=6/wd=0x22222222. Next cycle alu_gnt, then rf a3=5/wd=0x11111111.
- mem_req held continuously, md_req (addr 9, 0xdeadbeef) held -> md_gnt after exactly 4 denied RUN cycles, then rf a3=9/wd=0xdeadbeef. Starve counter returns to 0.
- alu_req with addr 0, data 0xffffffff -> alu_gnt=1, rf_wr=0 at the next edge.
- rst pulsed low between a grant and the following edge -> rf_wr=0 immediately. After release the init writes repeat before any gnt.
- (RF_WB_STAT_EN) 3 cycles with alu_req+mem_req high, 2 cycles with a single req -> conflict_cnt=3.
